clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 74 +++++++
 rtl/clock_set_ctrl_if.sv | 43 ++++
 rtl/month_len.sv | 25 ++
 rtl/clock_set_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock-setting controller and calendar counter.
package clock_pkg;

   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned HOUR_W  = 5;
   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;
   localparam int unsigned YEAR_W  = 14;

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      S_YEAR  = 3'd1,
      S_MONTH = 3'd2,
      S_DAY   = 3'd3,
      S_HOUR  = 3'd4,
      S_MIN   = 3'd5,
      S_SEC   = 3'd6,
      COMMIT  = 3'd7
   } state_e;

   localparam logic [2:0] FS_NONE  = 3'd0;
   localparam logic [2:0] FS_YEAR  = 3'd1;
   localparam logic [2:0] FS_MONTH = 3'd2;
   localparam logic [2:0] FS_DAY   = 3'd3;
   localparam logic [2:0] FS_HOUR  = 3'd4;
   localparam logic [2:0] FS_MIN   = 3'd5;
   localparam logic [2:0] FS_SEC   = 3'd6;

   localparam int unsigned SEC_MAX   = 59;
   localparam int unsigned MIN_MAX   = 59;
   localparam int unsigned HOUR_MAX  = 23;
   localparam int unsigned DAY_MIN   = 1;
   localparam int unsigned MONTH_MIN = 1;
   localparam int unsigned MONTH_MAX = 12;
   localparam int unsigned YEAR_MAX  = 9999;

   localparam int unsigned RST_YEAR  = 2024;
   localparam int unsigned RST_MONTH = 1;
   localparam int unsigned RST_DAY   = 1;

   typedef struct packed {
      logic [YEAR_W-1:0]  year;
      logic [MONTH_W-1:0] month;
      logic [DAY_W-1:0]   day;
      logic [HOUR_W-1:0]  hour;
      logic [MIN_W-1:0]   min;
      logic [SEC_W-1:0]   sec;
   } cal_t;

   localparam cal_t RST_CAL = '{
      year:  YEAR_W'(RST_YEAR),
      month: MONTH_W'(RST_MONTH),
      day:   DAY_W'(RST_DAY),
      hour:  '0,
      min:   '0,
      sec:   '0
   };

   // Wrapping +1/-1 inside [lo, hi]; simultaneous up and down leaves the value alone.
   function automatic logic [YEAR_W-1:0] step_field(input logic [YEAR_W-1:0] val,
                                                    input logic [YEAR_W-1:0] lo,
                                                    input logic [YEAR_W-1:0] hi,
                                                    input logic              up,
                                                    input logic              down);
      step_field = val;
      if (up && !down) begin
         step_field = (val >= hi) ? lo : val + YEAR_W'(1);
      end else if (down && !up) begin
         step_field = (val <= lo) ? hi : val - YEAR_W'(1);
      end
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, live-time, shadow-time and load handshake bundle between the setting
// controller (slave) and its surroundings (master).
interface clock_set_ctrl_if;
   import clock_pkg::*;

   logic               tick_1hz;
   logic               btn_mode;
   logic               btn_inc;
   logic               btn_dec;
   logic [SEC_W-1:0]   cur_sec;
   logic [MIN_W-1:0]   cur_min;
   logic [HOUR_W-1:0]  cur_hour;
   logic [DAY_W-1:0]   cur_day;
   logic [MONTH_W-1:0] cur_month;
   logic [YEAR_W-1:0]  cur_year;
   logic [SEC_W-1:0]   set_sec;
   logic [MIN_W-1:0]   set_min;
   logic [HOUR_W-1:0]  set_hour;
   logic [DAY_W-1:0]   set_day;
   logic [MONTH_W-1:0] set_month;
   logic [YEAR_W-1:0]  set_year;
   logic               load_req;
   logic               load_ack;
   logic               run_en;
   logic [2:0]         field_sel;

   modport master (
      output tick_1hz, btn_mode, btn_inc, btn_dec,
      output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
      output load_ack,
      input  set_sec, set_min, set_hour, set_day, set_month, set_year,
      input  load_req, run_en, field_sel
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc, btn_dec,
      input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
      input  load_ack,
      output set_sec, set_min, set_hour, set_day, set_month, set_year,
      output load_req, run_en, field_sel
   );

endinterface

// File: rtl/month_len.sv
// Days in a month for a given year (leap when year % 4 == 0); purely combinational.
module month_len
   import clock_pkg::*;
(
   input  logic [MONTH_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   output logic [DAY_W-1:0]   days_in_month_c
);

   logic leap_c;
   assign leap_c = ((year % YEAR_W'(4)) == '0);

   always_comb begin
      days_in_month_c = DAY_W'(31);
      case (month)
         MONTH_W'(2):  days_in_month_c = leap_c ? DAY_W'(29) : DAY_W'(28);
         MONTH_W'(4),
         MONTH_W'(6),
         MONTH_W'(9),
         MONTH_W'(11): days_in_month_c = DAY_W'(30);
         default:      days_in_month_c = DAY_W'(31);
      endcase
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time/date setting controller with shadow registers and load handshake.
// Optional idle timeout in set mode is enabled by defining SET_TIMEOUT_EN.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_S = 30
) (
   input  logic             clk,
   input  logic             rst_n,
   clock_set_ctrl_if.slave  bus
);

   state_e             state_q, state_d;
   cal_t               set_q, set_d, cur_c;
   logic [YEAR_W-1:0]  yr_c;
   logic [MONTH_W-1:0] mon_c;
   logic [DAY_W-1:0]   dim_cur_c, dim_new_c;
   logic               in_set_c, any_btn_c, edit_c, timeout_c;
   logic               run_en_q, run_en_d, load_req_q, load_req_d;
   logic [2:0]         field_sel_q, field_sel_d;

   assign cur_c = '{year: bus.cur_year, month: bus.cur_month, day: bus.cur_day,
                    hour: bus.cur_hour, min: bus.cur_min, sec: bus.cur_sec};

   assign in_set_c  = (state_q inside {S_YEAR, S_MONTH, S_DAY, S_HOUR, S_MIN, S_SEC});
   assign any_btn_c = bus.btn_mode | bus.btn_inc | bus.btn_dec;
   // Mode takes priority over inc/dec in the same cycle.
   assign edit_c    = in_set_c && !bus.btn_mode && (bus.btn_inc ^ bus.btn_dec);

`ifdef SET_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d     = cnt_q;
      timeout_c = 1'b0;
      if (!in_set_c || any_btn_c) begin
         cnt_d = '0;
      end else if (bus.tick_1hz) begin
         if (cnt_q == CNT_W'(TIMEOUT_S - 1)) begin
            timeout_c = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = bus.tick_1hz ^ (TIMEOUT_S == 0);
   assign timeout_c      = 1'b0;
`endif

   // Edited year/month feed the day clamp on the same edge.
   always_comb begin
      yr_c  = set_q.year;
      mon_c = set_q.month;
      if (edit_c && state_q == S_YEAR) begin
         yr_c = step_field(set_q.year, '0, YEAR_W'(YEAR_MAX), bus.btn_inc, bus.btn_dec);
      end
      if (edit_c && state_q == S_MONTH) begin
         mon_c = MONTH_W'(step_field(YEAR_W'(set_q.month), YEAR_W'(MONTH_MIN),
                                     YEAR_W'(MONTH_MAX), bus.btn_inc, bus.btn_dec));
      end
   end

   month_len u_dim_cur (.month(set_q.month), .year(set_q.year), .days_in_month_c(dim_cur_c));
   month_len u_dim_new (.month(mon_c),       .year(yr_c),       .days_in_month_c(dim_new_c));

   always_comb begin
      set_d = set_q;
      if (state_q == RUN && bus.btn_mode) begin
         set_d = cur_c;
      end else if (edit_c) begin
         set_d.year  = yr_c;
         set_d.month = mon_c;
         case (state_q)
            S_YEAR, S_MONTH: if (set_q.day > dim_new_c) set_d.day = dim_new_c;
            S_DAY:   set_d.day  = DAY_W'(step_field(YEAR_W'(set_q.day), YEAR_W'(DAY_MIN),
                                                    YEAR_W'(dim_cur_c), bus.btn_inc, bus.btn_dec));
            S_HOUR:  set_d.hour = HOUR_W'(step_field(YEAR_W'(set_q.hour), '0,
                                                     YEAR_W'(HOUR_MAX), bus.btn_inc, bus.btn_dec));
            S_MIN:   set_d.min  = MIN_W'(step_field(YEAR_W'(set_q.min), '0,
                                                    YEAR_W'(MIN_MAX), bus.btn_inc, bus.btn_dec));
            S_SEC:   set_d.sec  = SEC_W'(step_field(YEAR_W'(set_q.sec), '0,
                                                    YEAR_W'(SEC_MAX), bus.btn_inc, bus.btn_dec));
            default: set_d = set_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         set_q   <= RST_CAL;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.btn_mode) state_d = S_YEAR;
         S_YEAR:  if (bus.btn_mode) state_d = S_MONTH;
         S_MONTH: if (bus.btn_mode) state_d = S_DAY;
         S_DAY:   if (bus.btn_mode) state_d = S_HOUR;
         S_HOUR:  if (bus.btn_mode) state_d = S_MIN;
         S_MIN:   if (bus.btn_mode) state_d = S_SEC;
         S_SEC:   if (bus.btn_mode) state_d = COMMIT;
         COMMIT:  if (bus.load_ack) state_d = RUN;
         default: state_d = RUN;
      endcase
      if (timeout_c) state_d = RUN;
   end

   // Outputs decoded from the next state so they are registered yet aligned with it.
   always_comb begin
      run_en_d    = 1'b0;
      load_req_d  = 1'b0;
      field_sel_d = FS_NONE;
      case (state_d)
         RUN:     run_en_d    = 1'b1;
         S_YEAR:  field_sel_d = FS_YEAR;
         S_MONTH: field_sel_d = FS_MONTH;
         S_DAY:   field_sel_d = FS_DAY;
         S_HOUR:  field_sel_d = FS_HOUR;
         S_MIN:   field_sel_d = FS_MIN;
         S_SEC:   field_sel_d = FS_SEC;
         COMMIT:  load_req_d  = 1'b1;
         default: run_en_d    = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en_q    <= 1'b1;
         load_req_q  <= 1'b0;
         field_sel_q <= FS_NONE;
      end else begin
         run_en_q    <= run_en_d;
         load_req_q  <= load_req_d;
         field_sel_q <= field_sel_d;
      end
   end

   assign bus.set_year  = set_q.year;
   assign bus.set_month = set_q.month;
   assign bus.set_day   = set_q.day;
   assign bus.set_hour  = set_q.hour;
   assign bus.set_min   = set_q.min;
   assign bus.set_sec   = set_q.sec;
   assign bus.run_en    = run_en_q;
   assign bus.load_req  = load_req_q;
   assign bus.field_sel = field_sel_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: calendar-rule model checked every cycle plus literal pins.
module tb_clock_set_ctrl;
   localparam int unsigned TO = 3;

   logic clk;
   logic rst_n;
   clock_set_ctrl_if bus();

   clock_set_ctrl #(.TIMEOUT_S(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   int m_st, m_y, m_mo, m_d, m_h, m_mi, m_s;
`ifdef SET_TIMEOUT_EN
   int m_cnt;
`endif

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dim(input int mo, input int y);
      if (mo == 2) return (y % 4 == 0) ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   // Behavioural model: m_st 0 = running, 1..6 = field being edited, 7 = awaiting load.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_st = 0; m_y = 2024; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
`ifdef SET_TIMEOUT_EN
         m_cnt = 0;
`endif
      end else begin
         int pst;
         int dl;
         pst = m_st;
         if (m_st == 0) begin
            if (bus.btn_mode) begin
               m_y = int'(bus.cur_year); m_mo = int'(bus.cur_month); m_d = int'(bus.cur_day);
               m_h = int'(bus.cur_hour); m_mi = int'(bus.cur_min); m_s = int'(bus.cur_sec);
               m_st = 1;
            end
         end else if (m_st == 7) begin
            if (bus.load_ack) m_st = 0;
         end else if (bus.btn_mode) begin
            m_st = m_st + 1;
         end else if (bus.btn_inc != bus.btn_dec) begin
            dl = bus.btn_inc ? 1 : -1;
            case (m_st)
               1: begin m_y = (m_y + dl + 10000) % 10000; if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y); end
               2: begin m_mo = ((m_mo - 1 + dl + 12) % 12) + 1; if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y); end
               3: m_d = ((m_d - 1 + dl + dim(m_mo, m_y)) % dim(m_mo, m_y)) + 1;
               4: m_h = (m_h + dl + 24) % 24;
               5: m_mi = (m_mi + dl + 60) % 60;
               default: m_s = (m_s + dl + 60) % 60;
            endcase
         end
`ifdef SET_TIMEOUT_EN
         if (pst >= 1 && pst <= 6) begin
            if (bus.btn_mode || bus.btn_inc || bus.btn_dec) m_cnt = 0;
            else if (bus.tick_1hz) begin
               m_cnt++;
               if (m_cnt >= int'(TO)) begin m_st = 0; m_cnt = 0; end
            end
         end else m_cnt = 0;
`else
         if (pst < 0) m_st = 0;
`endif
      end
   end

   // Compare process on the falling edge, away from output updates.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("run_en",    int'(bus.run_en),    int'(m_st == 0));
         check("load_req",  int'(bus.load_req),  int'(m_st == 7));
         check("field_sel", int'(bus.field_sel), (m_st >= 1 && m_st <= 6) ? m_st : 0);
         check("set_year",  int'(bus.set_year),  m_y);
         check("set_month", int'(bus.set_month), m_mo);
         check("set_day",   int'(bus.set_day),   m_d);
         check("set_hour",  int'(bus.set_hour),  m_h);
         check("set_min",   int'(bus.set_min),   m_mi);
         check("set_sec",   int'(bus.set_sec),   m_s);
      end
   end

   task automatic step(input logic m, input logic i, input logic d, input logic t, input logic a);
      bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d; bus.tick_1hz = t; bus.load_ack = a;
      @(negedge clk);
   endtask

   task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
      bus.cur_year = 14'(y); bus.cur_month = 4'(mo); bus.cur_day = 5'(d);
      bus.cur_hour = 5'(h);  bus.cur_min = 6'(mi);   bus.cur_sec = 6'(s);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0; bus.tick_1hz = 0; bus.load_ack = 0;
      set_cur(2023, 1, 31, 23, 59, 59);
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("lit_rst_run_en", int'(bus.run_en), 1);
      check("lit_rst_year", int'(bus.set_year), 2024);
      check("lit_rst_day", int'(bus.set_day), 1);
      rst_n = 1'b1;
      step(0,0,0,0,0);

      // Session 1: full edit path through every field, then commit.
      step(1,0,0,0,0);
      check("lit_enter_fs", int'(bus.field_sel), 1);
      check("lit_enter_run_en", int'(bus.run_en), 0);
      check("lit_cap_year", int'(bus.set_year), 2023);
      check("lit_cap_sec", int'(bus.set_sec), 59);
      step(0,1,0,0,0); check("lit_year_inc", int'(bus.set_year), 2024);
      step(0,0,1,0,0);
      step(1,0,0,0,0);
      step(0,1,0,0,0);
      check("lit_feb_month", int'(bus.set_month), 2);
      check("lit_feb23_day", int'(bus.set_day), 28);
      step(0,0,1,0,0);
      step(0,0,1,0,0); check("lit_month_wrap", int'(bus.set_month), 12);
      step(0,1,0,0,0);
      step(0,1,1,0,0); check("lit_incdec_hold", int'(bus.set_month), 1);
      step(1,1,0,0,0);
      check("lit_mode_wins_fs", int'(bus.field_sel), 3);
      check("lit_mode_wins_mon", int'(bus.set_month), 1);
      repeat (3) step(0,1,0,0,0);
      step(0,1,0,0,0); check("lit_day_wrap", int'(bus.set_day), 1);
      step(0,0,1,0,0); check("lit_day_back", int'(bus.set_day), 31);
      step(1,0,0,0,0);
      step(0,1,0,0,0); check("lit_hour_wrap", int'(bus.set_hour), 0);
      step(0,0,0,1,0); step(0,0,0,1,0);
      step(0,1,0,0,0); step(0,0,1,0,0);
      step(1,0,0,0,0);
      step(0,0,1,0,0); check("lit_min_dec", int'(bus.set_min), 58);
      step(0,1,0,0,0);
      step(1,0,0,0,0);
      step(0,1,0,0,0); check("lit_sec_wrap", int'(bus.set_sec), 0);
      step(1,0,0,0,0); check("lit_commit_req", int'(bus.load_req), 1);
      step(0,1,0,0,0); check("lit_hold2", int'(bus.load_req), 1);
      step(1,0,0,0,0); check("lit_hold3", int'(bus.load_req), 1);
      step(0,0,1,0,0); check("lit_hold4", int'(bus.load_req), 1);
      step(0,0,0,0,0); check("lit_hold5", int'(bus.load_req), 1);
      check("lit_frozen_sec", int'(bus.set_sec), 0);
      step(0,0,0,0,1);
      check("lit_ack_req", int'(bus.load_req), 0);
      check("lit_ack_run", int'(bus.run_en), 1);
      step(0,0,0,0,1); check("lit_stray_ack", int'(bus.run_en), 1);

      // Session 2: leap-year February clamp from the 31st.
      set_cur(2024, 1, 31, 12, 30, 15);
      step(1,0,0,0,0); step(1,0,0,0,0);
      step(0,1,0,0,0); check("lit_feb24_day", int'(bus.set_day), 29);
      repeat (5) step(1,0,0,0,0);
      step(0,0,0,0,1);

      // Session 3: year change clamps Feb 29.
      set_cur(2024, 2, 29, 1, 2, 3);
      step(1,0,0,0,0);
      step(0,1,0,0,0); check("lit_year_clamp", int'(bus.set_day), 28);
      step(0,0,1,0,0);
      repeat (6) step(1,0,0,0,0);
      step(0,0,0,0,1);

      // Session 4: year wrap, then idle ticks in the hour field.
      set_cur(9999, 2, 28, 5, 6, 7);
      step(1,0,0,0,0);
      step(0,1,0,0,0); check("lit_year_wrap", int'(bus.set_year), 0);
      step(0,0,1,0,0); check("lit_year_back", int'(bus.set_year), 9999);
      repeat (3) step(1,0,0,0,0);
      check("lit_hour_fs", int'(bus.field_sel), 4);
      repeat (3) begin step(0,0,0,0,0); step(0,0,0,1,0); end
`ifdef SET_TIMEOUT_EN
      check("lit_timeout_run", int'(bus.run_en), 1);
`else
      check("lit_no_timeout", int'(bus.field_sel), 4);
`endif
      check("lit_idle_noreq", int'(bus.load_req), 0);
      #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      step(0,0,0,0,0);

      // Session 5: reset while a load is pending.
      repeat (7) step(1,0,0,0,0);
      check("lit_commit2_req", int'(bus.load_req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("lit_rst_commit_req", int'(bus.load_req), 0);
      check("lit_rst_commit_run", int'(bus.run_en), 1);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) step(0,0,0,0,0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
